uart_rx_cfg: RTL
================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter DATA_WIDTH, default 8, meaning: max data bits per frame; legal range 5..9.
REQ-002 Parameter PRESCALE_W, default 6, meaning: width of prescale input.
REQ-003 CLK  input  1  oversampling clock; all logic on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 RX_IN  input  1  serial line, idle high, asynchronous to CLK.
REQ-006 PAR_EN  input  1  1 = parity bit present after data.
REQ-007 PAR_TYP  input  1  0 = even, 1 = odd parity.
REQ-008 STOP2  input  1  1 = two stop bits, 0 = one.
REQ-009 prescale  input  PRESCALE_W  CLK cycles per bit.
REQ-010 P_DATA  output  DATA_WIDTH  received word, LSB = first data bit.
REQ-011 data_valid  output  1  one-cycle pulse, frame good.
REQ-012 par_err  output  1  one-cycle pulse, parity mismatch.
REQ-013 stp_err  output  1  one-cycle pulse, a stop bit sampled low.

Function
REQ-014 RX_IN SHALL pass through a 2-flop synchronizer (rx_s); all timing below refers to rx_s.
REQ-015 Effective prescale P SHALL be prescale with bit 0 forced to 0, clamped to a minimum of 4.
REQ-016 P, PAR_EN, PAR_TYP and STOP2 SHALL be latched on start detection; input changes mid-frame SHALL be ignored.
REQ-017 States SHALL be IDLE, START, DATA, PARITY, STOP; unused encodings SHALL go to IDLE.
REQ-018 IDLE: rx_s = 0 SHALL move to START next cycle with edge_cnt = 0.
REQ-019 edge_cnt SHALL increment every cycle outside IDLE and wrap from P-1 to 0; each wrap ends one bit window.
REQ-020 Each bit SHALL be sampled at edge_cnt = P/2-2, P/2-1 and P/2.
REQ-021 The bit value SHALL be the 2-of-3 majority, decided at edge_cnt = P/2+1.
REQ-022 START: majority 1 SHALL be a glitch; return to IDLE at the decision cycle with no output pulse.
REQ-023 START: majority 0 SHALL go to DATA at the window wrap.
REQ-024 DATA SHALL receive exactly DATA_WIDTH bits LSB-first, then go to PARITY if PAR_EN, else STOP.
REQ-025 PARITY: expected bit = XOR(data) XOR PAR_TYP; a mismatch SHALL set an internal error flag; go to STOP at the wrap.
REQ-026 STOP: any stop bit deciding 0 SHALL set the stop-error flag.
REQ-027 Two stop bits SHALL be checked when STOP2 = 1.
REQ-028 At the decision cycle of the last stop bit, the FSM SHALL return to IDLE without waiting for the window end, so back-to-back frames are accepted.
REQ-029 Outputs SHALL update in the cycle after the last stop decision.
REQ-030 No error: P_DATA SHALL load the word and data_valid SHALL pulse for 1 cycle.
REQ-031 Any error: the matching par_err and/or stp_err SHALL pulse for 1 cycle; data_valid SHALL stay 0; P_DATA SHALL hold its previous value.
REQ-032 par_err and stp_err SHALL be able to pulse in the same cycle.
REQ-033 P_DATA SHALL hold its value between frames.
REQ-034 A line held low (break) SHALL give stp_err; the FSM SHALL then stay in IDLE until rx_s has been 1 for at least 1 cycle before re-arming.

Reset
REQ-035 RST high SHALL, without waiting for CLK: set state to IDLE; clear edge_cnt, bit counter, shift register, P_DATA, data_valid, par_err and stp_err; set both synchronizer flops to 1.
REQ-036 RST asserted mid-frame SHALL abort the frame with no output pulse.
REQ-037 After RST release, the first falling edge SHALL be treated as a new start bit.

Verification
REQ-038 prescale=8, DATA_WIDTH=8, PAR_EN=0, STOP2=0, byte 0xA5 -> P_DATA=0xA5, one data_valid pulse, no error pulses.
REQ-039 prescale=16, PAR_EN=1, PAR_TYP=1, 0x3C with parity bit 1 -> data_valid, P_DATA=0x3C; repeat with parity bit 0 -> par_err only, P_DATA stays 0x3C.
REQ-040 prescale=4, STOP2=1, 0x81 with second stop bit low -> stp_err, no data_valid; then 0x81 with valid stops -> data_valid.
REQ-041 prescale=32, RX_IN low for 3 cycles then high -> no pulse, FSM back in IDLE; a single-cycle low inside a data bit -> majority-correct P_DATA.
REQ-042 Two frames 0x11 and 0xEE back-to-back at prescale=8 with no idle gap -> two data_valid pulses with the correct data.
REQ-043 RST pulse during bit 4 of a frame -> all outputs 0 immediately, no pulse; the next full frame is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop input synchronizer, 3-sample majority vote per bit,
// optional parity and one or two stop bits. Prescale and frame options are captured at start.
module uart_rx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    rxMeta_q, rxS_q;
  logic [PRESCALE_W-1:0]   edgeCnt_q, edgeCnt_d;
  logic [CNT_W-1:0]        bitCnt_q, bitCnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [2:0]              samp_q, samp_d;
  logic                    parErr_q, parErr_d;
  logic                    stopErr_q, stopErr_d;
  logic                    armed_q, armed_d;
  logic [PRESCALE_W-1:0]   pLat_q, pLat_d;
  logic                    parEn_q, parEn_d;
  logic                    parTyp_q, parTyp_d;
  logic                    stop2_q, stop2_d;
  logic [DATA_WIDTH-1:0]   pData_d;
  logic                    dataValid_d, parErrPulse_d, stpErrPulse_d;

  logic [PRESCALE_W-1:0]   pEven, pEff, halfP;
  logic                    isSample, isDec, isWrap, maj, lastStop;

  // Effective prescale: forced even, never below 4 so the sample points fit in a bit window.
  always_comb begin
    pEven = prescale & ~PRESCALE_W'(1);
    pEff  = (pEven < PRESCALE_W'(4)) ? PRESCALE_W'(4) : pEven;
  end

  always_comb begin
    halfP    = pLat_q >> 1;
    isSample = (edgeCnt_q == halfP - PRESCALE_W'(2)) ||
               (edgeCnt_q == halfP - PRESCALE_W'(1)) ||
               (edgeCnt_q == halfP);
    isDec    = (edgeCnt_q == halfP + PRESCALE_W'(1));
    isWrap   = (edgeCnt_q == pLat_q - PRESCALE_W'(1));
    maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    lastStop = !stop2_q || (bitCnt_q == CNT_W'(1));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rxMeta_q <= 1'b1;
      rxS_q    <= 1'b1;
    end else begin
      rxMeta_q <= RX_IN;
      rxS_q    <= rxMeta_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      edgeCnt_q  <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      samp_q     <= 3'b111;
      parErr_q   <= 1'b0;
      stopErr_q  <= 1'b0;
      armed_q    <= 1'b1;
      pLat_q     <= PRESCALE_W'(4);
      parEn_q    <= 1'b0;
      parTyp_q   <= 1'b0;
      stop2_q    <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      edgeCnt_q  <= edgeCnt_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      parErr_q   <= parErr_d;
      stopErr_q  <= stopErr_d;
      armed_q    <= armed_d;
      pLat_q     <= pLat_d;
      parEn_q    <= parEn_d;
      parTyp_q   <= parTyp_d;
      stop2_q    <= stop2_d;
      P_DATA     <= pData_d;
      data_valid <= dataValid_d;
      par_err    <= parErrPulse_d;
      stp_err    <= stpErrPulse_d;
    end
  end

  // Bit-level work (shift, parity, stop checks) happens at the decision count; state
  // advances at the window wrap, except the final stop bit which releases early.
  always_comb begin
    state_d       = state_q;
    edgeCnt_d     = edgeCnt_q;
    bitCnt_d      = bitCnt_q;
    shift_d       = shift_q;
    samp_d        = samp_q;
    parErr_d      = parErr_q;
    stopErr_d     = stopErr_q;
    armed_d       = armed_q;
    pLat_d        = pLat_q;
    parEn_d       = parEn_q;
    parTyp_d      = parTyp_q;
    stop2_d       = stop2_q;
    pData_d       = P_DATA;
    dataValid_d   = 1'b0;
    parErrPulse_d = 1'b0;
    stpErrPulse_d = 1'b0;

    if (state_q != IDLE) begin
      edgeCnt_d = isWrap ? '0 : edgeCnt_q + PRESCALE_W'(1);
      if (isSample) begin
        samp_d = {samp_q[1:0], rxS_q};
      end
    end

    case (state_q)
      IDLE: begin
        edgeCnt_d = '0;
        if (!armed_q) begin
          if (rxS_q) begin
            armed_d = 1'b1;
          end
        end else if (!rxS_q) begin
          state_d   = START;
          bitCnt_d  = '0;
          parErr_d  = 1'b0;
          stopErr_d = 1'b0;
          pLat_d    = pEff;
          parEn_d   = PAR_EN;
          parTyp_d  = PAR_TYP;
          stop2_d   = STOP2;
        end
      end

      START: begin
        if (isDec && maj) begin
          state_d   = IDLE;
          edgeCnt_d = '0;
        end else if (isWrap) begin
          state_d  = DATA;
          bitCnt_d = '0;
        end
      end

      DATA: begin
        if (isDec) begin
          shift_d  = {maj, shift_q[DATA_WIDTH-1:1]};
          bitCnt_d = bitCnt_q + CNT_W'(1);
        end
        if (isWrap && (bitCnt_d == CNT_W'(DATA_WIDTH))) begin
          state_d  = parEn_q ? PARITY : STOP;
          bitCnt_d = '0;
        end
      end

      PARITY: begin
        if (isDec && (maj != ((^shift_q) ^ parTyp_q))) begin
          parErr_d = 1'b1;
        end
        if (isWrap) begin
          state_d  = STOP;
          bitCnt_d = '0;
        end
      end

      STOP: begin
        if (isDec && !maj) begin
          stopErr_d = 1'b1;
        end
        if (isDec && lastStop) begin
          state_d       = IDLE;
          edgeCnt_d     = '0;
          armed_d       = maj;
          parErrPulse_d = parErr_q;
          stpErrPulse_d = stopErr_q | !maj;
          if (!parErr_q && !stopErr_q && maj) begin
            pData_d     = shift_q;
            dataValid_d = 1'b1;
          end
        end else if (isWrap) begin
          bitCnt_d = bitCnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        edgeCnt_d = '0;
      end
    endcase
  end

endmodule
